// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial bit source feeding the 1-bit input x of the downstream
//   sequence detector. Words arrive over a valid/ready handshake and are sent
//   one bit per clock. A one-word holding buffer lets back-to-back words stream
//   with no idle cycle between them.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous reset, active-high
//     load_valid  load_data is offered this cycle
//     load_ready  a word can be accepted this cycle (holding buffer empty)
//     load_data   word to serialise
//     stall       freeze serial output and bit counter
//     x           serial bit (decoded from registered state only)
//     x_valid     x carries a live data bit
//     busy        shifter or holding buffer occupied
//     done        high while the last bit of a word is on x
//     sent_count  completed words, wraps modulo 2^CNT_W
//
//   state | meaning
//   IDLE  | shifter empty, x=0, x_valid=0
//   SHIFT | shifter holds a word, current bit is on x
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  // Down-counter of bits still to come after the one on x; zero marks the last bit.
  logic [BW-1:0]    bits_left;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic             last_bit;
  logic             advance;

  assign load_ready = !hold_full;
  assign xfer       = load_valid && !hold_full;
  assign last_bit   = (state == SHIFT) && (bits_left == '0);
  assign advance    = (state == SHIFT) && !stall;
  assign sent_count = count;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bits_left <= '0;
      count     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (xfer) begin
            shifter   <= load_data;
            bits_left <= LAST_IDX;
          end
        end
        SHIFT: begin
          if (advance && last_bit) begin
            count <= count + CNT_W'(1);
            // Word boundary: refill from hold first, else straight from the input.
            // When hold is full load_ready is low, so both cannot happen at once.
            if (hold_full) begin
              shifter   <= hold;
              hold_full <= 1'b0;
              bits_left <= LAST_IDX;
            end else if (xfer) begin
              shifter   <= load_data;
              bits_left <= LAST_IDX;
            end
          end else begin
            if (advance) begin
              shifter   <= shifted;
              bits_left <= bits_left - BW'(1);
            end
            // Accepted while shifting or stalled, including on a stalled last bit.
            if (xfer) begin
              hold      <= load_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (MSB_FIRST) begin
      shifted = {shifter[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shifter[WIDTH-1:1]};
    end
    case (state)
      IDLE: begin
        if (xfer) state_next = SHIFT;
      end
      SHIFT: begin
        if (advance && last_bit && !hold_full && !xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    x       = 1'b0;
    x_valid = 1'b0;
    done    = 1'b0;
    busy    = hold_full;
    if (state == SHIFT) begin
      x_valid = 1'b1;
      x       = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
      done    = last_bit;
      busy    = 1'b1;
    end
  end

endmodule
